muu_value_get_mc: RTL and testbench

// - Successor response assembler for the muu value path: one header beat, then value beats, per lookup request.
// - Value width is parametric and fed from NUM_SRC value sources (memory read port, replication input, ...).

---
 rtl/muu_value_get_mc.sv | 179 +++++++++++++++++
 tb/tb_muu_value_get_mc.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muu_value_get_mc.sv
// Response assembler for the muu value path: one header beat, then the value beats of the selected source.
// Optional packet splitting is built when MUU_VALGET_PKTSPLIT_EN is defined.
module muu_value_get_mc #(
    parameter int META_WIDTH          = 96,
    parameter int DATA_WIDTH          = 512,
    parameter int NUM_SRC             = 2,
    parameter int LEN_WIDTH           = 10,
    parameter int USER_BITS           = 3,
    parameter int MAX_WORDS_IN_PACKET = 160
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [META_WIDTH-1:0]           req_meta,
    input  logic [LEN_WIDTH-1:0]            req_len,
    input  logic [1:0]                      req_src,
    input  logic                            req_drop,
    input  logic [USER_BITS-1:0]            req_user,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   val_data,
    input  logic [NUM_SRC-1:0]              val_valid,
    output logic [NUM_SRC-1:0]              val_ready,
    output logic [META_WIDTH+DATA_WIDTH-1:0] out_data,
    output logic [7:0]                      out_user,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready
);

    localparam int W  = DATA_WIDTH / 64;
    localparam int BW = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, HEADER, VALUE, DROP} state_t;

    state_t state, state_next;

    logic [META_WIDTH-1:0] meta_q;
    logic [1:0]            src_q;
    logic                  drop_q;
    logic [BW-1:0]         beats_q;

    logic                  out_free;
    logic                  req_accept;
    logic                  src_bad;
    logic                  hdr_last;
    logic                  val_last;
    logic                  sel_valid;
    logic                  val_hs;
    logic [BW-1:0]         req_beats;
    logic [BW-1:0]         hdr_beats;
    logic [7:0]            hdr_status;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic [DATA_WIDTH-1:0] hdr_word;
    logic [DATA_WIDTH-1:0] sel_data;

    assign out_free   = !out_valid || out_ready;
    assign req_ready  = !rst && (state == IDLE) && out_free;
    assign req_accept = req_valid && req_ready;
    assign src_bad    = 32'(req_src) >= 32'(NUM_SRC);

    // One extra bit keeps the rounding-up sum from wrapping at the maximum length.
    assign req_beats  = (BW'(req_len) + BW'(W - 1)) / BW'(W);
    assign hdr_beats  = src_bad ? '0 : req_beats;

    always_comb begin
        hdr_status = 8'd0;
        if (src_bad)
            hdr_status = 8'd2;
        else if (req_drop)
            hdr_status = 8'd1;
        hdr_len = (src_bad || req_drop) ? '0 : req_len;
        hdr_word = '0;
        hdr_word[15:0]            = 16'hFFFF;
        hdr_word[23:16]           = hdr_status;
        hdr_word[24 +: LEN_WIDTH] = hdr_len;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q == 2'(i)) begin
                sel_valid = val_valid[i];
                sel_data  = val_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Draining ignores output backpressure; forwarding waits for a free output register.
    assign val_hs = sel_valid && (((state == VALUE) && out_free) || (state == DROP));

    always_comb begin
        val_ready = '0;
        for (int i = 0; i < NUM_SRC; i++)
            val_ready[i] = !rst && val_hs && (src_q == 2'(i));
    end

`ifdef MUU_VALGET_PKTSPLIT_EN
    localparam int CNT_W = $clog2(MAX_WORDS_IN_PACKET + 1);

    logic [CNT_W-1:0] word_cnt;
    logic             split_hit;

    assign split_hit = (word_cnt == CNT_W'(MAX_WORDS_IN_PACKET - 1));
    assign hdr_last  = (hdr_beats == '0) || req_drop || split_hit;
    assign val_last  = (beats_q == BW'(1)) || split_hit;

    // Every loaded beat is eventually handshaken, so counting loads tracks output handshakes.
    always_ff @(posedge clk) begin
        if (rst)
            word_cnt <= '0;
        else if (req_accept)
            word_cnt <= hdr_last ? '0 : word_cnt + CNT_W'(1);
        else if ((state == VALUE) && val_hs)
            word_cnt <= val_last ? '0 : word_cnt + CNT_W'(1);
    end
`else
    assign hdr_last = (hdr_beats == '0) || req_drop;
    assign val_last = (beats_q == BW'(1));
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (req_accept) state_next = HEADER;
            HEADER: begin
                if (beats_q == '0)
                    state_next = IDLE;
                else if (drop_q)
                    state_next = DROP;
                else
                    state_next = VALUE;
            end
            VALUE,
            DROP:   if (val_hs && (beats_q == BW'(1))) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_user  <= '0;
            meta_q    <= '0;
            src_q     <= '0;
            drop_q    <= 1'b0;
            beats_q   <= '0;
        end else begin
            if (req_accept) begin
                meta_q    <= req_meta;
                src_q     <= req_src;
                drop_q    <= req_drop;
                beats_q   <= hdr_beats;
                out_data  <= {req_meta, hdr_word};
                out_user  <= 8'(req_user);
                out_last  <= hdr_last;
                out_valid <= 1'b1;
            end else if ((state == VALUE) && val_hs) begin
                out_data  <= {meta_q, sel_data};
                out_last  <= val_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (val_hs)
                beats_q <= beats_q - BW'(1);
        end
    end

endmodule

// File: tb/tb_muu_value_get_mc.sv
// Scoreboard bench for muu_value_get_mc: directed requests push expected beats, a monitor pops and compares.
module tb_muu_value_get_mc;

    localparam int MW = 96;
    localparam int DW = 512;
    localparam int NS = 2;
    localparam int OW = MW + DW;

    logic            clk;
    logic            rst;
    logic [MW-1:0]   req_meta;
    logic [9:0]      req_len;
    logic [1:0]      req_src;
    logic            req_drop;
    logic [2:0]      req_user;
    logic            req_valid;
    logic            req_ready;
    logic [NS*DW-1:0] val_data;
    logic [NS-1:0]   val_valid;
    logic [NS-1:0]   val_ready;
    logic [OW-1:0]   out_data;
    logic [7:0]      out_user;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;

    muu_value_get_mc #(
        .META_WIDTH(MW), .DATA_WIDTH(DW), .NUM_SRC(NS), .LEN_WIDTH(10),
        .USER_BITS(3), .MAX_WORDS_IN_PACKET(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_meta(req_meta), .req_len(req_len), .req_src(req_src), .req_drop(req_drop),
        .req_user(req_user), .req_valid(req_valid), .req_ready(req_ready),
        .val_data(val_data), .val_valid(val_valid), .val_ready(val_ready),
        .out_data(out_data), .out_user(out_user), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready)
    );

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
        logic [7:0]    user;
    } exp_t;

    exp_t           expQ[$];
    logic [DW-1:0]  src0Q[$];
    logic [DW-1:0]  src1Q[$];
    int             nChecks = 0;
    int             nFails = 0;
    int             beatsSeen = 0;
    int             cons0 = 0;
    int             cons1 = 0;
    logic [NS-1:0]  srcFire = '0;
    logic [NS-1:0]  vrSeen = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkWord(input int k);
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 64; j++)
            w[j*64 +: 64] = 64'hC0DE_0000_0000_0000 | (64'(k) << 8) | 64'(j);
        return w;
    endfunction

    function automatic logic [DW-1:0] hdrWord(input logic [7:0] status, input logic [9:0] len);
        logic [DW-1:0] h;
        h = '0;
        h[15:0]  = 16'hFFFF;
        h[23:16] = status;
        h[33:24] = len;
        return h;
    endfunction

    task automatic expectBeat(input logic [MW-1:0] meta, input logic [DW-1:0] word,
                              input logic last, input logic [2:0] user);
        exp_t e;
        e.data = {meta, word};
        e.last = last;
        e.user = {5'b0, user};
        expQ.push_back(e);
    endtask

    // Holds the request until the DUT takes it; inputs change on the falling edge only.
    task automatic applyStimulus(input logic [MW-1:0] meta, input logic [9:0] len, input logic [1:0] src,
                                 input logic drop, input logic [2:0] user);
        int  waitCnt = 0;
        bit  done = 0;
        @(negedge clk);
        req_meta  = meta;
        req_len   = len;
        req_src   = src;
        req_drop  = drop;
        req_user  = user;
        req_valid = 1;
        while (!done) begin
            #4;
            if (req_ready === 1'b1) done = 1;
            @(negedge clk);
            if (!done) begin
                waitCnt++;
                if (waitCnt > 300) begin
                    checkOutput("req_accept_timeout", 0, 1);
                    done = 1;
                end
            end
        end
        req_valid = 0;
    endtask

    task automatic waitBeats(input int n);
        int cnt = 0;
        while (beatsSeen < n && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (beatsSeen < n) checkOutput("beat_wait_timeout", OW'(beatsSeen), OW'(n));
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            srcFire = val_valid & val_ready;
            vrSeen  = vrSeen | val_ready;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                beatsSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", out_data, '0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("beat%0d_data", beatsSeen), out_data, e.data);
                    checkOutput($sformatf("beat%0d_last", beatsSeen), OW'(out_last), OW'(e.last));
                    checkOutput($sformatf("beat%0d_user", beatsSeen), OW'(out_user), OW'(e.user));
                end
            end
        end
    end

    // Source model: presents the queue head, pops it when the handshake happened.
    initial begin
        val_valid = '0;
        val_data  = '0;
        forever begin
            @(negedge clk);
            if (srcFire[0] && src0Q.size() > 0) begin void'(src0Q.pop_front()); cons0++; end
            if (srcFire[1] && src1Q.size() > 0) begin void'(src1Q.pop_front()); cons1++; end
            srcFire      = '0;
            val_valid[0] = (src0Q.size() > 0);
            val_valid[1] = (src1Q.size() > 0);
            val_data[0*DW +: DW] = (src0Q.size() > 0) ? src0Q[0] : '0;
            val_data[1*DW +: DW] = (src1Q.size() > 0) ? src1Q[0] : '0;
        end
    end

    initial begin
        logic [MW-1:0] m;
        logic [OW-1:0] snap;
        int            c0;
        int            base;
        bit            lastExp;

        rst = 1; out_ready = 1; req_valid = 0;
        req_meta = '0; req_len = '0; req_src = '0; req_drop = 0; req_user = '0;
        snap = '0;

        repeat (3) @(negedge clk);
        #4;
        checkOutput("rst_req_ready", OW'(req_ready), 0);
        @(negedge clk);
        rst = 0;
        #2;
        checkOutput("rst_out_valid", OW'(out_valid), 0);
        checkOutput("rst_out_last", OW'(out_last), 0);
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_out_user", OW'(out_user), 0);
        checkOutput("rst_val_ready", OW'(val_ready), 0);
        checkOutput("idle_req_ready", OW'(req_ready), 1);

        // len 0 with data waiting on src0: header only, source untouched
        m = 96'h1111_2222_3333_4444_5555_6666;
        src0Q.push_back(mkWord(99));
        vrSeen = '0;
        expectBeat(m, hdrWord(8'd0, 10'd0), 1, 3'd1);
        applyStimulus(m, 10'd0, 2'd0, 0, 3'd1);
        waitBeats(1);
        repeat (3) @(negedge clk);
        checkOutput("len0_no_val_ready", OW'(vrSeen), 0);
        checkOutput("len0_src0_kept", OW'(src0Q.size()), 1);
        src0Q.delete();
        repeat (2) @(negedge clk);

        // len 20 on W=8: header + 3 value beats
        m = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_0001;
        for (int k = 1; k <= 3; k++) src0Q.push_back(mkWord(k));
        expectBeat(m, hdrWord(8'd0, 10'd20), 0, 3'd2);
        expectBeat(m, mkWord(1), 0, 3'd2);
        expectBeat(m, mkWord(2), 0, 3'd2);
        expectBeat(m, mkWord(3), 1, 3'd2);
        base = beatsSeen;
        applyStimulus(m, 10'd20, 2'd0, 0, 3'd2);
        waitBeats(base + 4);
        repeat (3) @(negedge clk);
        checkOutput("len20_beats", OW'(beatsSeen - base), 4);

        // drop len 16: header only, 2 source beats drained, request side blocked meanwhile
        m = 96'h0D0D_0D0D_0D0D_0D0D_0D0D_0D0D;
        c0 = cons0;
        expectBeat(m, hdrWord(8'd1, 10'd0), 1, 3'd3);
        applyStimulus(m, 10'd16, 2'd0, 1, 3'd3);
        repeat (5) @(negedge clk);
        #2;
        checkOutput("drop_rdy_before", OW'(req_ready), 0);
        src0Q.push_back(mkWord(11));
        repeat (4) @(negedge clk);
        #2;
        checkOutput("drop_rdy_mid", OW'(req_ready), 0);
        checkOutput("drop_consumed1", OW'(cons0 - c0), 1);
        src0Q.push_back(mkWord(12));
        repeat (4) @(negedge clk);
        #2;
        checkOutput("drop_rdy_after", OW'(req_ready), 1);
        checkOutput("drop_consumed2", OW'(cons0 - c0), 2);

        // src1 selected while both sources are valid
        m = 96'h5151_5151_5151_5151_5151_5151;
        src0Q.push_back(mkWord(20));
        src1Q.push_back(mkWord(21));
        vrSeen = '0;
        expectBeat(m, hdrWord(8'd0, 10'd8), 0, 3'd4);
        expectBeat(m, mkWord(21), 1, 3'd4);
        base = beatsSeen;
        applyStimulus(m, 10'd8, 2'd1, 0, 3'd4);
        waitBeats(base + 2);
        repeat (3) @(negedge clk);
        checkOutput("src1_vr0_idle", OW'(vrSeen[0]), 0);
        checkOutput("src1_vr1_pulse", OW'(vrSeen[1]), 1);
        checkOutput("src1_src0_kept", OW'(src0Q.size()), 1);

        // bad source index
        m = 96'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        src1Q.push_back(mkWord(22));
        repeat (2) @(negedge clk);
        vrSeen = '0;
        expectBeat(m, hdrWord(8'd2, 10'd0), 1, 3'd5);
        base = beatsSeen;
        applyStimulus(m, 10'd8, 2'd3, 0, 3'd5);
        waitBeats(base + 1);
        repeat (3) @(negedge clk);
        checkOutput("bad_no_val_ready", OW'(vrSeen), 0);
        checkOutput("bad_src0_kept", OW'(src0Q.size()), 1);
        checkOutput("bad_src1_kept", OW'(src1Q.size()), 1);
        src0Q.delete();
        src1Q.delete();
        repeat (2) @(negedge clk);

        // backpressure for 5 cycles mid-value
        m = 96'h5757_0000_1111_2222_3333_4444;
        for (int k = 30; k < 34; k++) src0Q.push_back(mkWord(k));
        expectBeat(m, hdrWord(8'd0, 10'd32), 0, 3'd6);
        for (int k = 30; k < 34; k++) expectBeat(m, mkWord(k), k == 33, 3'd6);
        base = beatsSeen;
        applyStimulus(m, 10'd32, 2'd0, 0, 3'd6);
        waitBeats(base + 2);
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #4;
            if (i == 0) snap = out_data;
            else checkOutput("stall_data_stable", out_data, snap);
            checkOutput("stall_val_ready", OW'(val_ready), 0);
            checkOutput("stall_out_valid", OW'(out_valid), 1);
        end
        @(negedge clk);
        out_ready = 1;
        waitBeats(base + 5);
        repeat (3) @(negedge clk);
        checkOutput("stall_beats", OW'(beatsSeen - base), 5);

        // reset in the middle of a response
        m = 96'h7E57_7E57_7E57_7E57_7E57_7E57;
        out_ready = 0;
        for (int k = 40; k < 44; k++) src0Q.push_back(mkWord(k));
        applyStimulus(m, 10'd32, 2'd0, 0, 3'd7);
        repeat (3) @(negedge clk);
        rst = 1;
        #4;
        checkOutput("midrst_req_ready", OW'(req_ready), 0);
        @(negedge clk);
        #2;
        checkOutput("midrst_out_valid", OW'(out_valid), 0);
        checkOutput("midrst_val_ready", OW'(val_ready), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        #2;
        checkOutput("midrst_idle", OW'(req_ready), 1);
        out_ready = 1;
        src0Q.delete();
        repeat (2) @(negedge clk);

        // long response: split points depend on the build option
        m = 96'h5B17_5B17_5B17_5B17_5B17_5B17;
        for (int k = 50; k < 58; k++) src0Q.push_back(mkWord(k));
        for (int b = 1; b <= 9; b++) begin
`ifdef MUU_VALGET_PKTSPLIT_EN
            lastExp = (b == 4) || (b == 8) || (b == 9);
`else
            lastExp = (b == 9);
`endif
            if (b == 1) expectBeat(m, hdrWord(8'd0, 10'd64), lastExp, 3'd2);
            else        expectBeat(m, mkWord(48 + b), lastExp, 3'd2);
        end
        base = beatsSeen;
        applyStimulus(m, 10'd64, 2'd0, 0, 3'd2);
        waitBeats(base + 9);
        repeat (4) @(negedge clk);
        checkOutput("split_beats", OW'(beatsSeen - base), 9);

        checkOutput("scoreboard_empty", OW'(expQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
